// File: rtl/instr_fetcher.sv
// Instruction-fetch stage feeding the branch predictor.
//
// Holds the fetch PC, looks it up in a direct-mapped one-word-per-line
// instruction cache and, on a miss, reads one word through the memory
// controller handshake. Each instruction is handed to the predictor with a
// one-cycle if_success pulse; the stage then waits for the predicted next PC.
// A ROB misprediction (jump_wrong) redirects fetch to rob_jump_pc.
//
// Ports:
//   clk, rst                       clock (rising edge), async active-low reset
//   rdy                            global ready; all state frozen while low
//   jump_wrong, rob_jump_pc        misprediction flush and corrected PC
//   predictor_enable_if            predictor next PC valid
//   predictor_stall_if             predictor waiting on a JALR target
//   predict_jump_pc                predicted next fetch PC
//   iq_full                        instruction queue full; no new fetch starts
//   if_success                     one-cycle pulse: instruction delivered
//   if_instr_pc_itself             PC of the delivered instruction
//   if_instr_to_ask_for_prediction delivered instruction word
//   mem_fetch_req, mem_fetch_addr  memory read request (held until done)
//   mem_fetch_done, mem_fetch_instr memory response pulse and data
module instr_fetcher #(
    parameter int unsigned ICACHE_IDX_W = 6,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jump_wrong,
    input  logic [31:0] rob_jump_pc,
    input  logic        predictor_enable_if,
    input  logic        predictor_stall_if,
    input  logic [31:0] predict_jump_pc,
    input  logic        iq_full,
    output logic        if_success,
    output logic [31:0] if_instr_pc_itself,
    output logic [31:0] if_instr_to_ask_for_prediction,
    output logic        mem_fetch_req,
    output logic [31:0] mem_fetch_addr,
    input  logic        mem_fetch_done,
    input  logic [31:0] mem_fetch_instr
);

    localparam int unsigned Lines = 1 << ICACHE_IDX_W;
    localparam int unsigned TagW  = 32 - ICACHE_IDX_W - 2;

    typedef enum logic [1:0] {StFetch, StWaitMem, StWaitPred, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        succ_q, succ_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;

    logic [Lines-1:0] valid_q;
    logic [TagW-1:0]  tag_q  [Lines];
    logic [31:0]      data_q [Lines];

    logic [ICACHE_IDX_W-1:0] look_idx, fill_idx;
    logic [TagW-1:0]         look_tag, fill_tag;
    logic                    hit;
    logic                    fill_en;

    // Lookup uses the current PC; fills use the address of the outstanding
    // request, which differs from the PC after a flush into StDrain.
    assign look_idx = pc_q[ICACHE_IDX_W+1:2];
    assign look_tag = pc_q[31:ICACHE_IDX_W+2];
    assign fill_idx = addr_q[ICACHE_IDX_W+1:2];
    assign fill_tag = addr_q[31:ICACHE_IDX_W+2];
    assign hit      = valid_q[look_idx] && (tag_q[look_idx] == look_tag);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_d       = req_q;
        addr_d      = addr_q;
        succ_d      = 1'b0;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        fill_en     = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (!iq_full) begin
                    if (hit) begin
                        succ_d      = 1'b1;
                        out_pc_d    = pc_q;
                        out_instr_d = data_q[look_idx];
                        state_d     = StWaitPred;
                    end else begin
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = StWaitMem;
                    end
                end
            end
            StWaitMem: begin
                if (mem_fetch_done) begin
                    fill_en     = 1'b1;
                    req_d       = 1'b0;
                    succ_d      = 1'b1;
                    out_pc_d    = pc_q;
                    out_instr_d = mem_fetch_instr;
                    state_d     = StWaitPred;
                end
            end
            StWaitPred: begin
                // A pending JALR holds fetch even if enable is already high.
                if (predictor_enable_if && !predictor_stall_if) begin
                    pc_d    = predict_jump_pc & ~32'h3;
                    state_d = StFetch;
                end
            end
            StDrain: begin
                if (mem_fetch_done) begin
                    fill_en = 1'b1;
                    req_d   = 1'b0;
                    state_d = StFetch;
                end
            end
        endcase

        // Flush overrides everything except the cache fill of a completing read.
        if (jump_wrong) begin
            pc_d        = rob_jump_pc & ~32'h3;
            succ_d      = 1'b0;
            out_pc_d    = out_pc_q;
            out_instr_d = out_instr_q;
            addr_d      = addr_q;
            if (req_q && !mem_fetch_done) begin
                req_d   = 1'b1;
                state_d = StDrain;
            end else begin
                req_d   = 1'b0;
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            addr_q      <= 32'h0;
            succ_q      <= 1'b0;
            out_pc_q    <= 32'h0;
            out_instr_q <= 32'h0;
            valid_q     <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            succ_q      <= succ_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            if (fill_en) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (rdy && fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_fetch_instr;
        end
    end

    assign if_success                     = succ_q;
    assign if_instr_pc_itself             = out_pc_q;
    assign if_instr_to_ask_for_prediction = out_instr_q;
    assign mem_fetch_req                  = req_q;
    assign mem_fetch_addr                 = addr_q;

endmodule

// File: tb/tb_instr_fetcher.sv
// Scoreboard bench for instr_fetcher: directed stimulus pushes expected memory
// requests and deliveries into queues; a negedge monitor pops and compares.
module tb_instr_fetcher;

    logic        clk = 1'b0;
    logic        rst, rdy, jump_wrong, predictor_enable_if, predictor_stall_if, iq_full;
    logic [31:0] rob_jump_pc, predict_jump_pc, mem_fetch_instr;
    logic        mem_fetch_done;
    logic        if_success, mem_fetch_req;
    logic [31:0] if_instr_pc_itself, if_instr_to_ask_for_prediction, mem_fetch_addr;

    instr_fetcher #(.ICACHE_IDX_W(6), .RESET_PC(32'h0)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .rdy                            (rdy),
        .jump_wrong                     (jump_wrong),
        .rob_jump_pc                    (rob_jump_pc),
        .predictor_enable_if            (predictor_enable_if),
        .predictor_stall_if             (predictor_stall_if),
        .predict_jump_pc                (predict_jump_pc),
        .iq_full                        (iq_full),
        .if_success                     (if_success),
        .if_instr_pc_itself             (if_instr_pc_itself),
        .if_instr_to_ask_for_prediction (if_instr_to_ask_for_prediction),
        .mem_fetch_req                  (mem_fetch_req),
        .mem_fetch_addr                 (mem_fetch_addr),
        .mem_fetch_done                 (mem_fetch_done),
        .mem_fetch_instr                (mem_fetch_instr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_req_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_instr_q[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor
    logic        req_prev  = 1'b0;
    logic        succ_prev = 1'b0;
    logic [31:0] addr_prev = 32'h0;

    always @(negedge clk) begin
        if (!rst) begin
            req_prev  <= 1'b0;
            succ_prev <= 1'b0;
        end else begin
            if (if_success) begin
                check("pulse_width", {31'b0, succ_prev}, 32'h0);
                if (exp_pc_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_deliver: got pc %h, expected no delivery",
                             if_instr_pc_itself);
                end else begin
                    check("deliver_pc", if_instr_pc_itself, exp_pc_q.pop_front());
                    check("deliver_instr", if_instr_to_ask_for_prediction,
                          exp_instr_q.pop_front());
                end
            end
            if (mem_fetch_req && !req_prev) begin
                if (exp_req_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_req: got addr %h, expected no request",
                             mem_fetch_addr);
                end else begin
                    check("req_addr", mem_fetch_addr, exp_req_q.pop_front());
                end
            end else if (mem_fetch_req && req_prev) begin
                check("req_addr_stable", mem_fetch_addr, addr_prev);
            end
            req_prev  <= mem_fetch_req;
            succ_prev <= if_success;
            addr_prev <= mem_fetch_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_del(input logic [31:0] pc, input logic [31:0] instr);
        exp_pc_q.push_back(pc);
        exp_instr_q.push_back(instr);
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 50; i++) begin
            if (mem_fetch_req) return;
            tick();
        end
        n_checks++;
        n_errors++;
        $display("FAIL %s: got no mem_fetch_req within 50 cycles, expected request", name);
    endtask

    task automatic wait_deliver(input string name);
        for (int i = 0; i < 50; i++) begin
            if (if_success) return;
            tick();
        end
        n_checks++;
        n_errors++;
        $display("FAIL %s: got no if_success within 50 cycles, expected delivery", name);
    endtask

    task automatic mem_respond(input int delay, input logic [31:0] data,
                               input logic flush, input logic [31:0] rob_pc);
        wait_req("mem_wait_req");
        repeat (delay) tick();
        mem_fetch_done  = 1'b1;
        mem_fetch_instr = data;
        if (flush) begin
            jump_wrong  = 1'b1;
            rob_jump_pc = rob_pc;
        end
        tick();
        mem_fetch_done = 1'b0;
        jump_wrong     = 1'b0;
    endtask

    task automatic predict_pulse(input logic [31:0] pc);
        predictor_enable_if = 1'b1;
        predict_jump_pc     = pc;
        tick();
        predictor_enable_if = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; jump_wrong = 1'b0; rob_jump_pc = 32'h0;
        predictor_enable_if = 1'b0; predictor_stall_if = 1'b0; predict_jump_pc = 32'h0;
        iq_full = 1'b0; mem_fetch_done = 1'b0; mem_fetch_instr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_success", {31'b0, if_success}, 32'h0);
        check("rst_req", {31'b0, mem_fetch_req}, 32'h0);
        check("rst_addr", mem_fetch_addr, 32'h0);
        check("rst_pc_out", if_instr_pc_itself, 32'h0);
        check("rst_instr_out", if_instr_to_ask_for_prediction, 32'h0);
        rst = 1'b1;

        // Cold miss at reset PC
        exp_req_q.push_back(32'h0);
        push_del(32'h0, 32'h00000013);
        mem_respond(3, 32'h00000013, 1'b0, 32'h0);
        wait_deliver("cold_deliver");

        // Hit: one cycle after entering fetch, no request
        push_del(32'h0, 32'h00000013);
        predict_pulse(32'h0);
        check("hit_fetch_cycle", {31'b0, if_success}, 32'h0);
        tick();
        check("hit_latency", {31'b0, if_success}, 32'h1);
        check("hit_no_req", {31'b0, mem_fetch_req}, 32'h0);

        // JALR stall holds fetch even with enable high
        predictor_enable_if = 1'b1;
        predictor_stall_if  = 1'b1;
        predict_jump_pc     = 32'h100;
        repeat (3) begin
            tick();
            check("stall_no_req", {31'b0, mem_fetch_req}, 32'h0);
            check("stall_no_success", {31'b0, if_success}, 32'h0);
        end
        exp_req_q.push_back(32'h100);
        push_del(32'h100, 32'h00100093);
        predictor_stall_if = 1'b0;
        tick();
        predictor_enable_if = 1'b0;
        mem_respond(2, 32'h00100093, 1'b0, 32'h0);
        wait_deliver("stall_release_deliver");

        // 0x100 evicted 0x0 (same index): refetch misses
        exp_req_q.push_back(32'h0);
        push_del(32'h0, 32'h00000013);
        predict_pulse(32'h0);
        mem_respond(1, 32'h00000013, 1'b0, 32'h0);
        wait_deliver("alias_deliver");

        // Flush mid-miss: request for 0x40 drained, then 0x200 fetched
        exp_req_q.push_back(32'h40);
        predict_pulse(32'h40);
        wait_req("flush_req");
        jump_wrong  = 1'b1;
        rob_jump_pc = 32'h200;
        tick();
        jump_wrong = 1'b0;
        repeat (2) begin
            tick();
            check("drain_req_held", {31'b0, mem_fetch_req}, 32'h1);
            check("drain_addr_held", mem_fetch_addr, 32'h40);
        end
        exp_req_q.push_back(32'h200);
        push_del(32'h200, 32'h20000193);
        mem_respond(0, 32'h04000113, 1'b0, 32'h0);
        check("drain_no_success", {31'b0, if_success}, 32'h0);
        mem_respond(2, 32'h20000193, 1'b0, 32'h0);
        wait_deliver("flush_deliver");

        // Drained word was filled: 0x40 now hits
        push_del(32'h40, 32'h04000113);
        predict_pulse(32'h40);
        tick();
        check("drain_fill_hit", {31'b0, if_success}, 32'h1);

        // Backpressure
        iq_full = 1'b1;
        predict_pulse(32'h80);
        repeat (4) begin
            tick();
            check("iqfull_no_req", {31'b0, mem_fetch_req}, 32'h0);
            check("iqfull_no_success", {31'b0, if_success}, 32'h0);
        end
        exp_req_q.push_back(32'h80);
        push_del(32'h80, 32'h08000213);
        iq_full = 1'b0;
        wait_req("iqfull_release_req");

        // rdy low freezes everything, even a flush
        rdy         = 1'b0;
        jump_wrong  = 1'b1;
        rob_jump_pc = 32'h300;
        repeat (5) begin
            tick();
            check("rdy_req_frozen", {31'b0, mem_fetch_req}, 32'h1);
            check("rdy_addr_frozen", mem_fetch_addr, 32'h80);
            check("rdy_no_success", {31'b0, if_success}, 32'h0);
        end
        jump_wrong = 1'b0;
        rdy        = 1'b1;
        mem_respond(1, 32'h08000213, 1'b0, 32'h0);
        wait_deliver("rdy_deliver");

        // jump_wrong beats predictor enable
        push_del(32'h40, 32'h04000113);
        predictor_enable_if = 1'b1;
        predict_jump_pc     = 32'h0;
        jump_wrong          = 1'b1;
        rob_jump_pc         = 32'h40;
        tick();
        predictor_enable_if = 1'b0;
        jump_wrong          = 1'b0;
        wait_deliver("flush_vs_pred_deliver");

        // jump_wrong together with done: fill, no pulse, refetch hits
        exp_req_q.push_back(32'hC0);
        predict_pulse(32'hC0);
        push_del(32'hC0, 32'h0C000313);
        mem_respond(1, 32'h0C000313, 1'b1, 32'hC0);
        check("flush_done_no_success", {31'b0, if_success}, 32'h0);
        wait_deliver("flush_done_refetch");

        repeat (5) tick();
        check("leftover_deliveries", exp_pc_q.size(), 32'h0);
        check("leftover_requests", exp_req_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetcher.md
Name: instr_fetcher

Overview:
- Instruction-fetch stage directly upstream of the branch predictor.
- Holds the architectural fetch PC and looks it up in a small direct-mapped instruction cache. On a miss it fetches one word through the memory-controller handshake.
- Hands each fetched instruction and its PC to the predictor with a one-cycle success pulse, then waits for the predictor's next-PC before fetching again.
- Redirects to the ROB-supplied PC on a misprediction.

Parameters:
ICACHE_IDX_W, 6, log2 of cache lines (64 lines, one 32-bit word each)
RESET_PC, 32'h0, fetch PC after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
rdy  in  1  global ready; when low, all state frozen
jump_wrong  in  1  ROB misprediction flush
rob_jump_pc  in  32  correct PC after misprediction
predictor_enable_if  in  1  predictor's next PC is valid
predictor_stall_if  in  1  predictor waiting on JALR target
predict_jump_pc  in  32  predicted next fetch PC
iq_full  in  1  downstream instruction queue full; no new fetch starts
if_success  out  1  one-cycle pulse: instruction delivered
if_instr_pc_itself  out  32  PC of delivered instruction
if_instr_to_ask_for_prediction  out  32  delivered instruction word
mem_fetch_req  out  1  memory read request, held until done
mem_fetch_addr  out  32  word address of request
mem_fetch_done  in  1  one-cycle pulse: mem_fetch_instr valid
mem_fetch_instr  in  32  fetched word

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=FETCH, all cache valid bits cleared.
  - if_success=0, mem_fetch_req=0, mem_fetch_addr=0, instr/pc outputs=0.
- rdy=0: no register changes. Held mem_fetch_req stays asserted.
- Cache addressing:
  - index = pc[ICACHE_IDX_W+1:2]; tag = pc[31:ICACHE_IDX_W+2].
  - pc[1:0] ignored, always 0.
  - Lookup is combinational.
- if_success: registered, high for exactly one cycle per delivered instruction. Default 0 every cycle.
- States:
  - FETCH:
    - iq_full=1: stay.
    - Hit: next cycle drive if_success=1 with pc and cached word; go to WAIT_PRED. Latency 1 cycle.
    - Miss: next cycle mem_fetch_req=1, mem_fetch_addr=pc; go to WAIT_MEM.
  - WAIT_MEM:
    - Hold req and addr stable until mem_fetch_done.
    - On done: write line (valid, tag, word); drop req next cycle; pulse if_success with pc and mem_fetch_instr; go to WAIT_PRED.
  - WAIT_PRED:
    - predictor_enable_if=1 and predictor_stall_if=0: pc<=predict_jump_pc, go to FETCH.
    - predictor_stall_if=1: remain (JALR pending), even if enable is high.
  - DRAIN:
    - Request outstanding but discarded.
    - On mem_fetch_done: fill cache; no if_success; drop req; go to FETCH.
- jump_wrong (highest priority, any state):
  - pc<=rob_jump_pc; if_success forced 0 that cycle.
  - Next state FETCH, or DRAIN if a request is outstanding (WAIT_MEM without done).
  - If in DRAIN: stay in DRAIN, pc updated.
- Simultaneous events:
  - jump_wrong with mem_fetch_done in WAIT_MEM: fill cache, no if_success, go to FETCH at rob_jump_pc.
  - jump_wrong with predictor_enable_if: jump_wrong wins.
  - Fill and lookup of the same index in one cycle: lookup sees old contents.
- Eviction: a fill overwrites the line unconditionally (direct-mapped).

Test Plan:
- Reset/cold miss: rst low then high; mem returns 32'h00000013 after 3 cycles -> mem_fetch_req=1 with addr 0 until done, then if_success pulses once with pc 0 and instr 32'h00000013.
- Hit path: after the above, predict_jump_pc=0 with enable -> next fetch hits; if_success exactly 1 cycle after FETCH entry; no mem_fetch_req.
- JALR stall: enable=1 with stall=1 -> no new fetch. Later enable=1, stall=0, predict_jump_pc=32'h100 -> mem_fetch_addr=32'h100.
- Flush mid-miss: jump_wrong with rob_jump_pc=32'h200 while waiting on addr 32'h40 -> req held until done, no if_success for 32'h40, next request addr 32'h200.
- Backpressure and rdy: iq_full=1 in FETCH -> no request, no if_success until deasserted. rdy=0 for 5 cycles mid-WAIT_MEM -> all outputs frozen.
- Aliasing: fetch 32'h0 then 32'h100 (same index, ICACHE_IDX_W=6) then 32'h0 -> third fetch misses and issues mem_fetch_addr=32'h0.
